msf_bit_decoder: RTL
====================

// Module: msf_bit_decoder
// PURPOSE
//  Front end of the MSF receive chain. Filters and times the raw carrier-present input.
//  Classifies each second's carrier-off pattern into the {B,A} data bits and detects the
//  500 ms minute marker. Emits one bits_valid pulse per second to time_date_decoder.
// PARAMETERS
//  CLK_HZ        10000  clk_i frequency; must be a multiple of 100 (tick = CLK_HZ/100 cycles = 10 ms)
//  INVERT_INPUT  0      1: msf_i is low when carrier present (receiver-dependent)
// PORTS
//  clk_i                in   1  single clock
//  rst_i                in   1  asynchronous, active-high reset
//  msf_i                in   1  raw receiver output, asynchronous; 1 = carrier present (after INVERT_INPUT)
//  bits_valid_o         out  1  1-cycle pulse: one second classified
//  bits_is_second_00_o  out  1  qualifies bits_valid_o: this second is the minute marker (second 00)
//  bits_data_o          out  2  {B,A}; stable from the bits_valid_o pulse until the next pulse
//  locked_o             out  1  2+ consecutive seconds timed correctly
//  error_o              out  1  1-cycle pulse on any framing error
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, counters/filter cleared. Async assert, applies mid-second.
//  - Input path: 2-FF synchroniser, then XOR INVERT_INPUT, then sampled on each 10 ms tick.
//    3-sample majority filter gives `car`. Fall = `car` 1->0 between consecutive ticks.
//  - Timing unit: `pos` (7 bits) counts ticks since the current second's fall. pos=0 on fall.
//  - FSM, evaluated on ticks only:
//    HUNT: on fall -> BIT, pos=0. locked_o=0.
//    BIT: pos++. Sample A=~car at pos==15 and B=~car at pos==25.
//      off_all &= ~car on every tick pos<=45.
//      At pos==50: pulse bits_valid_o; bits_data_o={B,A}; bits_is_second_00_o=off_all, same cycle.
//      Then -> GAP. Falls at pos<50 are ignored (they are code 01 content).
//    GAP: pos++. Fall at 95<=pos<=105 -> BIT, pos=0, good_cnt++ (sat 2).
//      Fall at pos<95 -> error_o, good_cnt=0, -> BIT with pos=0 (resync on this edge).
//      pos==106 with no fall -> error_o, good_cnt=0, -> HUNT.
//  - Marker second (off 0..500 ms) emits data 2'b11 with is_second_00=1. It is always shifted
//    downstream like any other second; the 60-bit window then covers seconds 00..59.
//  - bits_is_second_00_o is 0 whenever bits_valid_o is 0.
//  - locked_o = (good_cnt==2); cleared same cycle as error_o.
//  - Latency: bits_valid_o occurs 500 ms (+0..2 ticks filter delay +2 clk sync) after the second's
//    falling carrier edge. Outputs are registered.
//  - Simultaneous tick and reset: reset wins. Fall on the same tick as pos==106: error wins (-> HUNT).
//  - A 61st second (leap) is emitted normally; framing is unaffected.
// STRUCTURE
//  - Shared package msf_pkg (msf_pkg.vh) holds localparams TICK_HZ=100, POS_A=15, POS_B=25,
//    POS_MARK=45, POS_EMIT=50, POS_EDGE_MIN=95, POS_EDGE_MAX=105, POS_TIMEOUT=106,
//    and FSM encodings HUNT/BIT/GAP. time_date_decoder may reuse the package.
//  - One sub-module: msf_tick_prescaler (CLK_HZ/100 divider, 1-cycle tick_o, async reset).
//  - Synchroniser, majority filter and FSM stay in this module.
// TESTING (CLK_HZ=1000 for sim speed; carrier model in 10 ms steps)
//  1. Off 100 ms, on 900 ms, x3 -> three pulses, data=00, is_second_00=0; locked_o=1 after the 3rd fall.
//  2. Patterns off300 / off200 / off100-on100-off100 -> data 11 / 01 / 10 respectively
//     (A=bit0: off200 gives A=1 B=0 -> 2'b01).
//  3. Off 500 ms -> bits_valid_o and bits_is_second_00_o high in the same cycle, data=11.
//     Full 60 s MSF frame into time_date_decoder -> its valid_o fires at the next marker with
//     the correct time/date.
//  4. Next fall at 900 ms -> error_o pulse, locked_o=0, resync; no fall by 1060 ms -> error_o, FSM=HUNT.
//  5. Single 10 ms glitch (off) in on-phase -> no fall detected, no error. Glitch at pos 15 does not flip A.
//  6. Assert rst_i at pos==30 -> all outputs 0 immediately; after release a new fall restarts
//     cleanly and no stale bits_valid_o occurs.

Source files
------------

// File: rtl/msf_pkg.sv
// Shared MSF receive-chain definitions: tick rate, pulse-position landmarks
// (in 10 ms ticks after the falling carrier edge), FSM states and a 3-input
// majority helper. time_date_decoder may import this package as well.
package msf_pkg;

    localparam int unsigned TICK_HZ = 100;

    localparam logic [6:0] POS_A        = 7'd15;
    localparam logic [6:0] POS_B        = 7'd25;
    localparam logic [6:0] POS_MARK     = 7'd45;
    localparam logic [6:0] POS_EMIT     = 7'd50;
    localparam logic [6:0] POS_EDGE_MIN = 7'd95;
    localparam logic [6:0] POS_EDGE_MAX = 7'd105;
    localparam logic [6:0] POS_TIMEOUT  = 7'd106;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        BIT  = 2'd1,
        GAP  = 2'd2
    } msf_state_e;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/msf_tick_prescaler.sv
// 10 ms tick generator: divides clk_i by CLK_HZ/TICK_HZ.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   tick_o - one clk_i cycle high every CLK_HZ/TICK_HZ cycles
module msf_tick_prescaler
    import msf_pkg::*;
#(
    parameter int unsigned CLK_HZ = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/msf_bit_decoder.sv
// MSF front end: synchronises and majority-filters the carrier input, times
// each second from its falling carrier edge, classifies the {B,A} bits and
// flags the 500 ms minute marker. One bits_valid_o pulse per second.
// Ports:
//   clk_i               - clock (CLK_HZ)
//   rst_i               - asynchronous active-high reset
//   msf_i               - raw receiver output (1 = carrier, after INVERT_INPUT)
//   bits_valid_o        - 1-cycle pulse, one second classified
//   bits_is_second_00_o - with bits_valid_o: this second is the minute marker
//   bits_data_o         - {B,A}, held until the next bits_valid_o
//   locked_o            - two or more consecutive well-timed seconds
//   error_o             - 1-cycle pulse on a framing error
module msf_bit_decoder
    import msf_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 10000,
    parameter logic        INVERT_INPUT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       msf_i,
    output logic       bits_valid_o,
    output logic       bits_is_second_00_o,
    output logic [1:0] bits_data_o,
    output logic       locked_o,
    output logic       error_o
);

    logic tick;

    msf_tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    logic [1:0] sync_q;
    logic [2:0] samp_q, samp_d;
    logic       car_q, car_new, fall, raw;
    msf_state_e state_q, state_d;
    logic [6:0] pos_q, pos_d, pos_inc;
    logic       a_q, a_d, b_q, b_d, off_all_q, off_all_d;
    logic [1:0] good_q, good_d;
    logic       valid_q, valid_d, mark_q, mark_d, err_q, err_d, locked_q, locked_d;
    logic [1:0] data_q, data_d;

    always_comb begin
        raw      = sync_q[1] ^ INVERT_INPUT;
        samp_d   = {samp_q[1:0], raw};
        car_new  = maj3(samp_d);
        fall     = car_q & ~car_new;
        pos_inc  = pos_q + 7'd1;

        state_d   = state_q;
        pos_d     = pos_q;
        a_d       = a_q;
        b_d       = b_q;
        off_all_d = off_all_q;
        good_d    = good_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        mark_d    = 1'b0;
        err_d     = 1'b0;

        if (tick) begin
            case (state_q)
                HUNT: begin
                    if (fall) begin
                        state_d   = BIT;
                        pos_d     = '0;
                        off_all_d = 1'b1;
                    end
                end
                BIT: begin
                    // Falls inside the data window are bit content, not framing.
                    pos_d = pos_inc;
                    if (pos_inc == POS_A) a_d = ~car_new;
                    if (pos_inc == POS_B) b_d = ~car_new;
                    if (pos_inc <= POS_MARK) off_all_d = off_all_q & ~car_new;
                    if (pos_inc == POS_EMIT) begin
                        valid_d = 1'b1;
                        data_d  = {b_q, a_q};
                        mark_d  = off_all_q;
                        state_d = GAP;
                    end
                end
                GAP: begin
                    pos_d = pos_inc;
                    // Timeout is tested first so a fall on that tick still drops to HUNT.
                    if (pos_inc == POS_TIMEOUT) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = HUNT;
                    end else if (fall) begin
                        if (pos_inc >= POS_EDGE_MIN && pos_inc <= POS_EDGE_MAX) begin
                            good_d = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
                        end else begin
                            err_d  = 1'b1;
                            good_d = '0;
                        end
                        state_d   = BIT;
                        pos_d     = '0;
                        off_all_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (good_d == 2'd2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            samp_q    <= '0;
            car_q     <= 1'b0;
            state_q   <= HUNT;
            pos_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            off_all_q <= 1'b0;
            good_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            mark_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], msf_i};
            if (tick) begin
                samp_q <= samp_d;
                car_q  <= car_new;
            end
            state_q   <= state_d;
            pos_q     <= pos_d;
            a_q       <= a_d;
            b_q       <= b_d;
            off_all_q <= off_all_d;
            good_q    <= good_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            mark_q    <= mark_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign bits_valid_o        = valid_q;
    assign bits_is_second_00_o = mark_q;
    assign bits_data_o         = data_q;
    assign locked_o            = locked_q;
    assign error_o             = err_q;

endmodule
